// File: rtl/apple2_bus_master.sv
// Apple II slot-bus master: turns host read/write requests into 7M-timed
// PHI1/PHI0 bus cycles with slot select decode and read-data capture.
module apple2_bus_master #(
    parameter int unsigned SLOT      = 1,
    parameter logic [15:0] IDLE_ADDR = 16'hFFFF
) (
    input  logic        C7M,
    input  logic        RES,
    input  logic        ReqValid,
    input  logic        ReqWr,
    input  logic [15:0] ReqAddr,
    input  logic [7:0]  ReqWData,
    output logic        ReqReady,
    output logic        RspValid,
    output logic [7:0]  RspData,
    output logic        PHI0,
    output logic        PHI1,
    output logic [15:0] A,
    output logic        nWE,
    output logic        nDEVSEL,
    output logic        nIOSEL,
    output logic        nIOSTRB,
    input  logic [7:0]  Din,
    output logic [7:0]  Dout,
    output logic        DOE
);

    typedef enum logic [2:0] {
        S1 = 3'd0,
        S2 = 3'd1,
        S3 = 3'd2,
        S4 = 3'd3,
        S5 = 3'd4,
        S6 = 3'd5,
        S7 = 3'd6,
        S8 = 3'd7
    } state_t;

    localparam logic [6:0] LONG_CYCLE = 7'd64;

    state_t      state_r;
    state_t      state_s;
    logic [6:0]  cyc_r;
    logic [6:0]  cyc_s;
    logic        busy_r;
    logic        wr_r;
    logic [7:0]  wdata_r;
    logic        end_s;
    logic        nxt_final_s;
    logic        nxt_phi0_s;
    logic        nxt_late_s;
    logic        drive_s;

    function automatic logic devsel_hit(input logic [15:0] addr);
        logic [11:0] base;
        base = 12'hC08 + 12'(SLOT);
        return addr[15:4] == base;
    endfunction

    function automatic logic iosel_hit(input logic [15:0] addr);
        logic [7:0] page;
        page = 8'hC0 + 8'(SLOT);
        return addr[15:8] == page;
    endfunction

    function automatic logic iostrb_hit(input logic [15:0] addr);
        return addr[15:11] == 5'b11001;
    endfunction

    // Next-state logic: S7 ends the cycle except on cycle 64, which stretches into S8.
    always_comb begin
        state_s = state_r;
        cyc_s   = cyc_r;
        case (state_r)
            S1: state_s = S2;
            S2: state_s = S3;
            S3: state_s = S4;
            S4: state_s = S5;
            S5: state_s = S6;
            S6: state_s = S7;
            S7: begin
                if (cyc_r == LONG_CYCLE) begin
                    state_s = S8;
                end else begin
                    state_s = S1;
                    cyc_s   = cyc_r + 7'd1;
                end
            end
            S8: begin
                state_s = S1;
                cyc_s   = 7'd0;
            end
            default: begin
                state_s = S1;
                cyc_s   = 7'd0;
            end
        endcase
    end

    // Decode of the upcoming state so every bus output can be registered in step with it.
    always_comb begin
        end_s       = (state_r == S8) || ((state_r == S7) && (cyc_r != LONG_CYCLE));
        nxt_final_s = (state_s == S8) || ((state_s == S7) && (cyc_s != LONG_CYCLE));
        nxt_phi0_s  = (state_s != S1) && (state_s != S2) && (state_s != S3);
        nxt_late_s  = nxt_phi0_s && (state_s != S4);
        drive_s     = nxt_late_s && busy_r && wr_r;
    end

    // Sequencer, phase clocks and handshake; reset idles the bus at once.
    always_ff @(posedge C7M or posedge RES) begin
        if (RES) begin
            state_r  <= S1;
            cyc_r    <= 7'd0;
            PHI1     <= 1'b1;
            PHI0     <= 1'b0;
            ReqReady <= 1'b0;
            RspValid <= 1'b0;
            RspData  <= 8'h00;
            A        <= IDLE_ADDR;
            nWE      <= 1'b1;
            busy_r   <= 1'b0;
            wr_r     <= 1'b0;
            wdata_r  <= 8'h00;
        end else begin
            state_r  <= state_s;
            cyc_r    <= cyc_s;
            PHI1     <= ~nxt_phi0_s;
            PHI0     <= nxt_phi0_s;
            ReqReady <= nxt_final_s;
            RspValid <= 1'b0;
            if (end_s) begin
                // Completing cycle reports back while the next one is loaded.
                if (busy_r) begin
                    RspValid <= 1'b1;
                    RspData  <= wr_r ? 8'h00 : Din;
                end
                if (ReqValid) begin
                    A       <= ReqAddr;
                    nWE     <= ~ReqWr;
                    busy_r  <= 1'b1;
                    wr_r    <= ReqWr;
                    wdata_r <= ReqWData;
                end else begin
                    A       <= IDLE_ADDR;
                    nWE     <= 1'b1;
                    busy_r  <= 1'b0;
                    wr_r    <= 1'b0;
                    wdata_r <= 8'h00;
                end
            end
        end
    end

    // Slot selects and write-data drive, valid only while PHI0 is high.
    always_ff @(posedge C7M or posedge RES) begin
        if (RES) begin
            nDEVSEL <= 1'b1;
            nIOSEL  <= 1'b1;
            nIOSTRB <= 1'b1;
            DOE     <= 1'b0;
            Dout    <= 8'h00;
        end else begin
            nDEVSEL <= ~(nxt_phi0_s && devsel_hit(A));
            nIOSEL  <= ~(nxt_phi0_s && iosel_hit(A));
            nIOSTRB <= ~(nxt_phi0_s && iostrb_hit(A));
            DOE     <= drive_s;
            Dout    <= drive_s ? wdata_r : 8'h00;
        end
    end

endmodule

// File: tb/tb_apple2_bus_master.sv
// Bench for apple2_bus_master (SLOT=1): a reference bus-cycle sequence plus
// table-driven transactions and sequences for back-to-back and reset cases.
module tb_apple2_bus_master;

    logic        C7M = 1'b0;
    logic        RES = 1'b1;
    logic        ReqValid = 1'b0;
    logic        ReqWr = 1'b0;
    logic [15:0] ReqAddr = 16'h0000;
    logic [7:0]  ReqWData = 8'h00;
    logic [7:0]  Din = 8'h00;
    logic        ReqReady, RspValid, PHI0, PHI1, nWE, nDEVSEL, nIOSEL, nIOSTRB, DOE;
    logic [7:0]  RspData, Dout;
    logic [15:0] A;

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        logic        dev;
        logic        io;
        logic        strb;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vecs [12];

    always #5 C7M = ~C7M;

    apple2_bus_master #(.SLOT(1), .IDLE_ADDR(16'hFFFF)) dut (
        .C7M(C7M), .RES(RES), .ReqValid(ReqValid), .ReqWr(ReqWr),
        .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqReady(ReqReady),
        .RspValid(RspValid), .RspData(RspData), .PHI0(PHI0), .PHI1(PHI1),
        .A(A), .nWE(nWE), .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .nIOSTRB(nIOSTRB),
        .Din(Din), .Dout(Dout), .DOE(DOE)
    );

    // Reference bus-cycle position: S1..S7 (S8 on cycle 64), cycles 0..64.
    int model_st = 1;
    int model_cyc = 0;
    int model_total = 0;
    always @(posedge C7M or posedge RES) begin
        if (RES) begin
            model_st <= 1; model_cyc <= 0; model_total <= 0;
        end else if (model_st == 7 && model_cyc != 64) begin
            model_st <= 1; model_cyc <= model_cyc + 1; model_total <= model_total + 1;
        end else if (model_st == 7) begin
            model_st <= 8;
        end else if (model_st == 8) begin
            model_st <= 1; model_cyc <= 0; model_total <= model_total + 1;
        end else begin
            model_st <= model_st + 1;
        end
    end

    function automatic bit model_final();
        return (model_st == 8) || (model_st == 7 && model_cyc != 64);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge C7M) begin
        if (mon_en)
            check("phase", {PHI1, PHI0, ReqReady},
                  {(model_st <= 3), (model_st >= 4), model_final()});
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ReqReady !== 1'b1 && n < 20) begin
            @(negedge C7M);
            n++;
        end
        check(name, (n < 20), 1'b1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        logic ph, late;
        ReqValid = 1'b1; ReqWr = v.wr; ReqAddr = v.addr; ReqWData = v.wdata; Din = v.din;
        wait_ready($sformatf("vec%0d_accept", idx));
        @(negedge C7M);
        ReqValid = 1'b0;
        n = 0;
        do begin
            ph   = (model_st >= 4);
            late = v.wr && (model_st >= 5);
            check($sformatf("vec%0d_bus_s%0d", idx, model_st),
                  {A, nWE, nDEVSEL, nIOSEL, nIOSTRB, DOE, (late ? Dout : 8'h00), RspValid},
                  {v.addr, !v.wr, !(v.dev && ph), !(v.io && ph), !(v.strb && ph), late,
                   (late ? v.wdata : 8'h00), 1'b0});
            @(negedge C7M);
            n++;
        end while (model_st != 1 && n < 12);
        check($sformatf("vec%0d_rsp", idx), {RspValid, RspData}, {1'b1, v.rdata});
        @(negedge C7M);
        check($sformatf("vec%0d_rsp_hold", idx), {RspValid, RspData}, {1'b0, v.rdata});
    endtask

    int run, longs, n, prev;
    logic [7:0] tp_exp [3];

    initial begin
        vecs[0]  = '{1'b0, 16'hC093, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h5A};
        vecs[1]  = '{1'b1, 16'hC100, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 16'hCFFF, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C};
        vecs[3]  = '{1'b0, 16'hC800, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hC3};
        vecs[4]  = '{1'b0, 16'hC090, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[5]  = '{1'b0, 16'hC09F, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 8'h80};
        vecs[6]  = '{1'b0, 16'hC08F, 8'h00, 8'h7E, 1'b0, 1'b0, 1'b0, 8'h7E};
        vecs[7]  = '{1'b0, 16'hC0A0, 8'h00, 8'hE7, 1'b0, 1'b0, 1'b0, 8'hE7};
        vecs[8]  = '{1'b1, 16'hC1FF, 8'h0F, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 16'hC7FF, 8'h00, 8'h99, 1'b0, 1'b0, 1'b0, 8'h99};
        vecs[10] = '{1'b1, 16'h0000, 8'hFF, 8'h12, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 16'hC200, 8'h00, 8'h6D, 1'b0, 1'b0, 1'b0, 8'h6D};

        // Reset state, with a request pending that must not be accepted.
        RES = 1'b1; ReqValid = 1'b1; ReqAddr = 16'hC093;
        repeat (3) @(negedge C7M);
        check("reset_state",
              {PHI1, PHI0, A, nWE, nDEVSEL, nIOSEL, nIOSTRB, DOE, Dout, ReqReady, RspValid, RspData},
              {1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
        ReqValid = 1'b0;
        RES = 1'b0;
        mon_en = 1'b1;

        // Free run over 130 idle cycles.
        run = 0; longs = 0;
        do begin
            @(negedge C7M);
            check("idle_bus", {A, nWE, nDEVSEL, nIOSEL, nIOSTRB, DOE, RspValid},
                  {16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
            if (PHI0 === 1'b1) begin
                run++;
            end else if (run > 0) begin
                check($sformatf("phi0_len_c%0d", model_total - 1), run,
                      (((model_total - 1) % 65) == 64) ? 5 : 4);
                if (run == 5) longs++;
                run = 0;
            end
        end while (model_total != 130);
        check("long_cycles", longs, 2);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Back-to-back requests across the long cycle (cycle 64).
        n = 0;
        while (!((model_total % 65) == 62 && model_st == 2) && n < 2000) begin
            @(negedge C7M);
            n++;
        end
        check("tp_align", (n < 2000), 1'b1);
        tp_exp[0] = 8'h11; tp_exp[1] = 8'h33; tp_exp[2] = 8'h00;
        ReqValid = 1'b1; ReqWr = 1'b0; ReqAddr = 16'hC093; Din = 8'h11;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ready($sformatf("tp_ready%0d", k));
            if (k > 0) check($sformatf("tp_consec%0d", k), model_total - prev, 1);
            prev = model_total;
            if (k == 2) begin
                check("tp_long_s8", model_st, 8);
                Din = 8'h33;
            end
            if (k == 3) ReqValid = 1'b0;
            @(negedge C7M);
            if (k == 0) check("tp_rsp_none", RspValid, 1'b0);
            else check($sformatf("tp_rsp%0d", k - 1), {RspValid, RspData}, {1'b1, tp_exp[k - 1]});
            if (k == 0) begin
                ReqAddr = 16'hC0A0;
            end else if (k == 1) begin
                Din = 8'h22; ReqWr = 1'b1; ReqAddr = 16'hC100; ReqWData = 8'h77;
            end
        end
        @(negedge C7M);
        check("tp_rsp_end", RspValid, 1'b0);

        // Reset in S5 of a write.
        ReqValid = 1'b1; ReqWr = 1'b1; ReqAddr = 16'hC100; ReqWData = 8'hA5;
        wait_ready("rst_accept");
        @(negedge C7M);
        ReqValid = 1'b0;
        n = 0;
        while (model_st != 5 && n < 10) begin
            @(negedge C7M);
            n++;
        end
        check("rst_pre", {DOE, Dout, nIOSEL}, {1'b1, 8'hA5, 1'b0});
        mon_en = 1'b0;
        ReqValid = 1'b1;
        RES = 1'b1;
        #1;
        check("rst_async",
              {DOE, Dout, nIOSEL, nDEVSEL, nIOSTRB, A, nWE, PHI1, PHI0, ReqReady, RspValid, RspData},
              {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        repeat (2) @(negedge C7M);
        check("rst_no_accept", ReqReady, 1'b0);
        ReqValid = 1'b0;
        RES = 1'b0;
        mon_en = 1'b1;
        @(negedge C7M);
        @(negedge C7M);
        check("rst_s3_phi0", PHI0, 1'b0);
        @(negedge C7M);
        check("rst_s4_phi0", PHI0, 1'b1);
        n = 0;
        repeat (21) begin
            @(negedge C7M);
            if (RspValid === 1'b1) n++;
        end
        check("rst_no_rsp", n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apple2_bus_master.md
APPLE2_BUS_MASTER -- requirements
Module: apple2_bus_master

Interface
REQ-001 SHALL have parameter SLOT, default 1, slot number 1-7 used for select decode.
REQ-002 SHALL have parameter IDLE_ADDR, default 16'hFFFF, address driven on idle bus cycles.
REQ-003 SHALL have port C7M, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RES, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port ReqValid, input, 1, host request pending.
REQ-006 SHALL have port ReqWr, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have port ReqAddr, input, 16, request address.
REQ-008 SHALL have port ReqWData, input, 8, write data.
REQ-009 SHALL have port ReqReady, output, 1, request accepted when high together with ReqValid.
REQ-010 SHALL have port RspValid, output, 1, one-C7M pulse marking completion of an accepted request.
REQ-011 SHALL have port RspData, output, 8, read data; 8'h00 for writes.
REQ-012 SHALL have ports PHI0 and PHI1, output, 1 each, Apple II phase clocks.
REQ-013 SHALL have port A, output, 16, address bus.
REQ-014 SHALL have port nWE, output, 1, R/W (low = write).
REQ-015 SHALL have ports nDEVSEL, nIOSEL, nIOSTRB, output, 1 each, active-low slot selects.
REQ-016 SHALL have ports Din (input, 8), Dout (output, 8), DOE (output, 1), card data bus split into in, out and enable.

Function
REQ-017 SHALL run a state counter S through S1..S7 per bus cycle; S8 is inserted after S7 on long cycles; every cycle runs continuously, whether or not a request is pending.
REQ-018 SHALL count bus cycles 0..64 with a 7-bit counter that wraps 64->0; cycle 64 is a long cycle (8 C7M periods), all other cycles are 7 C7M periods.
REQ-019 SHALL output registered PHI1=1, PHI0=0 in S1-S3 and PHI1=0, PHI0=1 in S4..final state; the two phases are never both high.
REQ-020 SHALL sample ReqValid only in the final state (S7, or S8 on a long cycle); ReqReady=1 only in that state.
REQ-021 SHALL load A, nWE and the write data on entry to S1: the accepted request's values, or IDLE_ADDR with nWE=1 when nothing was accepted.
REQ-022 SHALL hold A and nWE stable from S1 through the final state.
REQ-023 SHALL assert nDEVSEL low in S4..final only when A is in the range C080+16*SLOT .. C08F+16*SLOT.
REQ-024 SHALL assert nIOSEL low in S4..final only when A[15:8] = C0+SLOT.
REQ-025 SHALL assert nIOSTRB low in S4..final only when A is in the range C800..CFFF.
REQ-026 SHALL deassert all selects on the same edge on which PHI0 falls.
REQ-027 SHALL drive DOE=1 with Dout=write data in S5..final of write cycles only; DOE=0 at all other times.
REQ-028 SHALL capture Din on the rising edge that ends the final state of a read cycle.
REQ-029 SHALL pulse RspValid for exactly one C7M period in S1 of the following cycle, for reads and writes, and never for idle cycles.
REQ-030 SHALL hold RspData stable until the next RspValid.
REQ-031 SHALL allow back-to-back requests: an acceptance in every cycle yields one RspValid per cycle, with no idle cycle inserted.
REQ-032 SHALL not accept a request while RES is high.

Reset
REQ-033 SHALL, while RES=1, force S=S1 and cycle counter=0.
REQ-034 SHALL, while RES=1, force PHI1=1, PHI0=0, A=IDLE_ADDR, nWE=1, all selects=1, DOE=0, Dout=00, ReqReady=0, RspValid=0, RspData=00.
REQ-035 SHALL advance to S2 on the first rising edge after RES falls.
REQ-036 SHALL, on reset mid-request, abandon the request with no RspValid and return all bus outputs to idle immediately (asynchronously).

Verification
REQ-037 SHALL verify free-run: no requests for 130 cycles -> PHI1 high for 3 clocks and PHI0 high for 4 clocks per cycle, PHI0 high for 5 clocks on every 65th cycle, selects never asserted.
REQ-038 SHALL verify read: SLOT=1, ReqAddr=C093 (read), Din=5A -> nDEVSEL low S4-S7 only, nWE=1, DOE=0, RspValid with RspData=5A.
REQ-039 SHALL verify write: ReqAddr=C100, ReqWData=A5 -> nIOSEL low S4-S7 only, nWE=0, DOE=1 with Dout=A5 in S5-S7, RspValid with RspData=00.
REQ-040 SHALL verify strobe: ReqAddr=CFFF read -> nIOSTRB low in PHI0 only, nIOSEL and nDEVSEL stay high.
REQ-041 SHALL verify throughput: ReqValid held high across 3 requests, one spanning the long cycle -> 3 consecutive bus cycles, 3 RspValid pulses, the long cycle samples Din at S8.
REQ-042 SHALL verify reset mid-operation: RES asserted in S5 of a write -> DOE=0 and selects high immediately, no RspValid, S2 on the first edge after release.
